dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder for the RISC-V core: the target side of the `memread`/`memwrite` strobes that the main control decoder asserts for loads and stores. It accepts one access per instruction, inserts a parameterised number of wait states, and holds the pipeline with `stall` meanwhile. It performs byte/half/word stores with byte enables and sign- or zero-extends loads. Misaligned, unsupported or out-of-range accesses are reported instead of executed.

## Interface
- `DEPTH_WORDS`, 256: memory size in 32-bit words; power of two.
- `WAIT_STATES`, 2: extra cycles between request acceptance and response; 0 is legal.
- Ports:
- `clk`  in  1  sole clock; rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `memread`  in  1  load request from control.
- `memwrite`  in  1  store request from control.
- `funct3`  in  3  access size/sign, RV32I encoding.
- `addr`  in  32  byte address from the ALU.
- `wdata`  in  32  store data (rs2), lane 0 aligned.
- `rdata`  out  32  extended load result, registered.
- `rvalid`  out  1  one-cycle pulse: access completed (load or store).
- `fault`  out  1  valid with `rvalid`: access rejected.
- `stall`  out  1  pipeline hold request.

## Operation
- FSM states IDLE, WAIT, RESP; reset state IDLE.
- IDLE: `memread` or `memwrite` high -> latch `addr`, `funct3`, `wdata`, op; go to WAIT if `WAIT_STATES`>0 (counter loaded with `WAIT_STATES`-1), else RESP. Neither high -> stay.
- WAIT: counter decrements each cycle; at 0 go to RESP.
- RESP: access performed at the clock edge entering RESP (store written, load data registered); `rvalid`=1 for this one cycle; next state IDLE unconditionally.
- `memread` and `memwrite` both high: accepted, no memory write, completes with `fault`=1, `rdata`=0.
- Loads: `funct3` 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; others are faults.
- Stores: `funct3` 000 SB, 001 SH, 010 SW; others are faults.
- Little-endian; the byte lane comes from `addr[1:0]`. Sub-word stores write only the enabled bytes. Loads sign-extend for LB/LH and zero-extend for LBU/LHU.
- Fault conditions:
  - halfword access with `addr[0]`=1;
  - word access with `addr[1:0]`≠0;
  - word index `addr[31:2]` ≥ `DEPTH_WORDS`;
  - illegal `funct3`.
- A faulted access writes nothing and returns `rdata`=0.
- `rdata` holds its last value outside RESP; it is updated only on load completions and faults.
- Memory contents are not cleared by reset and are undefined at power-up.

## Timing
- Reset values: `rdata`=0, `rvalid`=0, `fault`=0, `stall`=0, state IDLE, counter 0.
- `stall` is combinational:
  - high in IDLE while a request is present;
  - high throughout WAIT;
  - low in RESP.
- Request sampled in cycle N:
  - `stall` high for cycles N..N+`WAIT_STATES`;
  - `rvalid`/`rdata`/`fault` valid in cycle N+1+`WAIT_STATES`.
- The datapath holds request inputs stable while `stall` is high. Inputs are ignored in WAIT and RESP.
- Request still high in the RESP cycle belongs to the completing instruction. Back-to-back instructions are sampled from the following IDLE cycle, so peak throughput is one access per `WAIT_STATES`+2 cycles.
- `rst_n` low mid-access:
  - immediate return to IDLE;
  - pending store discarded, no partial write;
  - all outputs to reset values.

## Structure
- Shared package `mem_pkg`:
  - funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW);
  - FSM state enum;
  - `ACC_BYTE`/`ACC_HALF`/`ACC_WORD` size enum.
- Sub-module `lsu_align` (combinational):
  - store path: byte-enable and write-lane steering from `addr[1:0]`/`funct3`;
  - load path: lane extraction and sign/zero extension;
  - misalignment and illegal-`funct3` detect.
- Top holds the FSM, wait counter, request latches and the memory array.

## Test plan
- SW 0xDEADBEEF @0x10, then LW @0x10, `WAIT_STATES`=2:
  - `stall` high 3 cycles;
  - `rvalid` on the 4th cycle;
  - `rdata`=0xDEADBEEF.
- SB 0x80 @0x13 over 0x00000000, then check loads:
  - LB @0x13 -> 0xFFFFFF80;
  - LBU @0x13 -> 0x00000080;
  - LW @0x10 -> 0x80000000.
- SH 0x1234 @0x21 -> `fault`=1 with `rvalid`; LW @0x20 unchanged; LH @0x22 with mem 0x8001xxxx -> 0xFFFF8001.
- LW @ (`DEPTH_WORDS`×4) -> `fault`=1, `rdata`=0. `memread`=`memwrite`=1 -> `fault`=1, no write.
- `WAIT_STATES`=0: LW back-to-back each held until stall drops -> `stall` 1 cycle per access, `rvalid` every 2 cycles.
- SW 0xCAFEF00D @0x30 with `rst_n` pulsed low in WAIT -> outputs zero immediately, FSM IDLE, subsequent LW @0x30 returns prior contents.

Source files
------------

// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
//   Shared definitions for the data-memory responder and its alignment unit:
//   RV32I load/store funct3 encodings, the responder FSM state type, and the
//   access-size type with a helper that derives it from funct3.
// ---------------------------------------------------------------------------
package mem_pkg;

  // Load encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store encodings
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // ACC_NONE marks the funct3[1:0]=11 encodings, which no access uses.
  typedef enum logic [1:0] {
    ACC_BYTE = 2'd0,
    ACC_HALF = 2'd1,
    ACC_WORD = 2'd2,
    ACC_NONE = 2'd3
  } acc_size_e;

  function automatic acc_size_e f3_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return ACC_BYTE;
      2'b01:   return ACC_HALF;
      2'b10:   return ACC_WORD;
      default: return ACC_NONE;
    endcase
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// ---------------------------------------------------------------------------
// dmem_responder_if
//   Load/store bus between the core datapath (master) and the data-memory
//   responder (slave).
//   memread/memwrite : access strobes from the control decoder
//   funct3           : access size / sign (RV32I)
//   addr, wdata      : byte address and lane-0-aligned store data
//   rdata            : extended load result (registered in the responder)
//   rvalid, fault    : completion pulse and its rejection flag
//   stall            : pipeline hold request
// ---------------------------------------------------------------------------
interface dmem_responder_if;
  logic        memread;
  logic        memwrite;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rvalid;
  logic        fault;
  logic        stall;

  modport master (
    output memread, memwrite, funct3, addr, wdata,
    input  rdata, rvalid, fault, stall
  );

  modport slave (
    input  memread, memwrite, funct3, addr, wdata,
    output rdata, rvalid, fault, stall
  );
endinterface

// File: rtl/lsu_align.sv
// ---------------------------------------------------------------------------
// lsu_align  (combinational)
//   Byte-lane steering for one load/store access.
//   i_is_load  : 1 = load, 0 = store (selects which funct3 set is legal)
//   i_funct3   : access size / sign
//   i_addr_lo  : addr[1:0], selects the byte lane
//   i_wdata    : store data, lane 0 aligned
//   i_rword    : memory word addressed by the access
//   o_be       : byte enables for the store
//   o_wword    : store data replicated onto every candidate lane
//   o_rdata    : extracted and sign/zero-extended load data
//   o_fault    : misaligned access or illegal funct3
// ---------------------------------------------------------------------------
module lsu_align
  import mem_pkg::*;
(
  input  logic        i_is_load,
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  output logic [3:0]  o_be,
  output logic [31:0] o_wword,
  output logic [31:0] o_rdata,
  output logic        o_fault
);

  acc_size_e   w_size;
  logic        w_legal;
  logic        w_misalign;
  logic        w_signed;
  logic [31:0] w_shifted;

  always_comb begin
    w_size     = f3_size(i_funct3);
    w_legal    = i_is_load ? (i_funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU})
                           : (i_funct3 inside {F3_SB, F3_SH, F3_SW});
    w_misalign = ((w_size == ACC_HALF) && i_addr_lo[0]) ||
                 ((w_size == ACC_WORD) && (i_addr_lo != 2'b00));
    o_fault    = !w_legal || w_misalign;

    // funct3[2] set means the unsigned load variants
    w_signed   = !i_funct3[2];
    // Bring the addressed lane down to bit 0 before extension
    w_shifted  = i_rword >> {i_addr_lo, 3'b000};

    o_be    = 4'b0000;
    o_wword = i_wdata;
    o_rdata = 32'h0;
    case (w_size)
      ACC_BYTE: begin
        o_be    = 4'b0001 << i_addr_lo;
        o_wword = {4{i_wdata[7:0]}};
        o_rdata = {{24{w_signed & w_shifted[7]}}, w_shifted[7:0]};
      end
      ACC_HALF: begin
        o_be    = 4'b0011 << i_addr_lo;
        o_wword = {2{i_wdata[15:0]}};
        o_rdata = {{16{w_signed & w_shifted[15]}}, w_shifted[15:0]};
      end
      ACC_WORD: begin
        o_be    = 4'b1111;
        o_rdata = w_shifted;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
//   Target side of the core's data-memory strobes. Accepts one access,
//   waits WAIT_STATES cycles while holding stall, then performs the store or
//   registers the load result and pulses rvalid. Rejected accesses
//   (misaligned, illegal funct3, out of range, read+write together) write
//   nothing and return rdata=0 with fault=1.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : dmem_responder_if slave port (strobes, address, data, status)
// ---------------------------------------------------------------------------
module dmem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  dmem_responder_if.slave bus
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  state_e        r_state;
  state_e        w_state_next;
  logic [CW-1:0] r_cnt;
  logic          r_op_rd;
  logic          r_op_wr;
  logic [2:0]    r_funct3;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [31:0]   r_rdata;
  logic          r_rvalid;
  logic          r_fault;
  logic [31:0]   r_mem [DEPTH_WORDS];

  logic          w_req;
  logic          w_in_idle;
  logic          w_cur_rd;
  logic          w_cur_wr;
  logic [2:0]    w_cur_f3;
  logic [31:0]   w_cur_addr;
  logic [31:0]   w_cur_wdata;
  logic [AW-1:0] w_idx;
  logic          w_oor;
  logic          w_align_fault;
  logic          w_fault;
  logic          w_exec;
  logic          w_we;
  logic [3:0]    w_be;
  logic [31:0]   w_wword;
  logic [31:0]   w_rword;
  logic [31:0]   w_ld_data;

  assign w_req     = bus.memread | bus.memwrite;
  assign w_in_idle = (r_state == ST_IDLE);

  // With zero wait states the access executes on the accepting edge, so the
  // live bus must feed the datapath in IDLE; otherwise the latched copy does.
  assign w_cur_rd    = w_in_idle ? bus.memread  : r_op_rd;
  assign w_cur_wr    = w_in_idle ? bus.memwrite : r_op_wr;
  assign w_cur_f3    = w_in_idle ? bus.funct3   : r_funct3;
  assign w_cur_addr  = w_in_idle ? bus.addr     : r_addr;
  assign w_cur_wdata = w_in_idle ? bus.wdata    : r_wdata;

  assign w_idx   = w_cur_addr[AW+1:2];
  assign w_oor   = |w_cur_addr[31:AW+2];
  assign w_rword = r_mem[w_idx];

  lsu_align u_align (
    .i_is_load (w_cur_rd),
    .i_funct3  (w_cur_f3),
    .i_addr_lo (w_cur_addr[1:0]),
    .i_wdata   (w_cur_wdata),
    .i_rword   (w_rword),
    .o_be      (w_be),
    .o_wword   (w_wword),
    .o_rdata   (w_ld_data),
    .o_fault   (w_align_fault)
  );

  assign w_fault = (w_cur_rd & w_cur_wr) | w_oor | w_align_fault;
  // The access happens on the edge that enters RESP
  assign w_exec  = (w_state_next == ST_RESP);
  assign w_we    = w_exec & w_cur_wr & !w_fault;

  always_comb begin
    w_state_next = r_state;
    bus.stall    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        bus.stall = w_req;
        if (w_req) w_state_next = (WAIT_STATES > 0) ? ST_WAIT : ST_RESP;
      end
      ST_WAIT: begin
        bus.stall = 1'b1;
        if (r_cnt == '0) w_state_next = ST_RESP;
      end
      ST_RESP: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_op_rd  <= 1'b0;
      r_op_wr  <= 1'b0;
      r_funct3 <= 3'b000;
      r_addr   <= 32'h0;
      r_wdata  <= 32'h0;
      r_rdata  <= 32'h0;
      r_rvalid <= 1'b0;
      r_fault  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_in_idle && w_req) begin
        r_op_rd  <= bus.memread;
        r_op_wr  <= bus.memwrite;
        r_funct3 <= bus.funct3;
        r_addr   <= bus.addr;
        r_wdata  <= bus.wdata;
        r_cnt    <= CNT_LOAD;
      end else if ((r_state == ST_WAIT) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end
      r_rvalid <= w_exec;
      r_fault  <= w_exec & w_fault;
      // rdata only moves on load completions and faults; stores leave it
      if (w_exec) begin
        if (w_fault)       r_rdata <= 32'h0;
        else if (w_cur_rd) r_rdata <= w_ld_data;
      end
    end
  end

  // Memory array: no reset, contents undefined at power-up
  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][b*8 +: 8] <= w_wword[b*8 +: 8];
      end
    end
  end

  assign bus.rdata  = r_rdata;
  assign bus.rvalid = r_rvalid;
  assign bus.fault  = r_fault;

endmodule

// File: tb/tb_dmem_responder.sv
// ---------------------------------------------------------------------------
// tb_dmem_responder
//   Directed bench for two responders (WAIT_STATES=2 and WAIT_STATES=0).
//   Expected responses are queued when an access is driven and compared
//   when rvalid appears; stall length and response latency are checked too.
// ---------------------------------------------------------------------------
module tb_dmem_responder;
  import mem_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder_if bus_a ();
  dmem_responder_if bus_b ();

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a)
  );
  dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b)
  );

  typedef struct {
    logic        flt;
    logic [31:0] rd;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] hold_rd [2];
  bit          in_resp [2];
  int          last_rv [2];
  int          spacing;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int s, input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    if (s == 0) begin
      bus_a.memread = rd; bus_a.memwrite = wr; bus_a.funct3 = f3;
      bus_a.addr = a; bus_a.wdata = wd;
    end else begin
      bus_b.memread = rd; bus_b.memwrite = wr; bus_b.funct3 = f3;
      bus_b.addr = a; bus_b.wdata = wd;
    end
  endtask

  function automatic logic get_stall(input int s);
    return (s == 0) ? bus_a.stall : bus_b.stall;
  endfunction
  function automatic logic get_rvalid(input int s);
    return (s == 0) ? bus_a.rvalid : bus_b.rvalid;
  endfunction
  function automatic logic get_fault(input int s);
    return (s == 0) ? bus_a.fault : bus_b.fault;
  endfunction
  function automatic logic [31:0] get_rdata(input int s);
    return (s == 0) ? bus_a.rdata : bus_b.rdata;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    in_resp[0] = 1'b0;
    in_resp[1] = 1'b0;
  endtask

  // One access: push expectation, hold request while stall is high, wait
  // (bounded) for rvalid, then pop and compare. Ends inside the RESP cycle.
  task automatic access(input int s, input string tag, input logic rd, input logic wr,
                        input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                        input logic exp_flt, input logic [31:0] exp_ld);
    int   ws;
    int   stall_cnt;
    int   lat;
    exp_t e;
    ws        = (s == 0) ? 2 : 0;
    stall_cnt = 0;
    lat       = -1;
    e.flt     = exp_flt;
    e.rd      = exp_flt ? 32'h0 : (rd ? exp_ld : hold_rd[s]);
    hold_rd[s] = e.rd;
    sb_q.push_back(e);

    drive(s, rd, wr, f3, a, wd);
    if (in_resp[s]) @(negedge clk);
    #1;
    for (int c = 0; c < 20; c++) begin
      if (get_stall(s)) stall_cnt++;
      if (get_rvalid(s)) begin
        lat = c;
        break;
      end
      @(negedge clk);
      #1;
    end
    drive(s, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    in_resp[s] = 1'b1;
    spacing    = cyc - last_rv[s];
    last_rv[s] = cyc;

    e = sb_q.pop_front();
    $display("access %s: lat=%0d stall=%0d fault=%0b rdata=0x%08h", tag, lat,
             stall_cnt, get_fault(s), get_rdata(s));
    check({tag, ":latency"}, 32'(lat), 32'(ws + 1));
    check({tag, ":stall_cycles"}, 32'(stall_cnt), 32'(ws + 1));
    check({tag, ":fault"}, {31'h0, get_fault(s)}, {31'h0, e.flt});
    check({tag, ":rdata"}, get_rdata(s), e.rd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    hold_rd[0] = 32'h0; hold_rd[1] = 32'h0;
    in_resp[0] = 1'b0;  in_resp[1] = 1'b0;
    last_rv[0] = 0;     last_rv[1] = 0;
    spacing    = 0;
    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    repeat (3) @(negedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      check("reset:rdata",  get_rdata(s), 32'h0);
      check("reset:rvalid", {31'h0, get_rvalid(s)}, 32'h0);
      check("reset:fault",  {31'h0, get_fault(s)},  32'h0);
      check("reset:stall",  {31'h0, get_stall(s)},  32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // ---- WAIT_STATES = 2 ----
    access(0, "sw_10",      1'b0, 1'b1, F3_SW,  32'h10, 32'hDEADBEEF, 1'b0, 32'h0);
    access(0, "lw_10",      1'b1, 1'b0, F3_LW,  32'h10, 32'h0,        1'b0, 32'hDEADBEEF);
    idle(2);
    check("hold:rdata", get_rdata(0), 32'hDEADBEEF);
    access(0, "sw_10_zero", 1'b0, 1'b1, F3_SW,  32'h10, 32'h0,        1'b0, 32'h0);
    access(0, "sb_13",      1'b0, 1'b1, F3_SB,  32'h13, 32'h12345680, 1'b0, 32'h0);
    access(0, "lb_13",      1'b1, 1'b0, F3_LB,  32'h13, 32'h0,        1'b0, 32'hFFFFFF80);
    access(0, "lbu_13",     1'b1, 1'b0, F3_LBU, 32'h13, 32'h0,        1'b0, 32'h00000080);
    access(0, "lw_10_b",    1'b1, 1'b0, F3_LW,  32'h10, 32'h0,        1'b0, 32'h80000000);
    access(0, "lh_12",      1'b1, 1'b0, F3_LH,  32'h12, 32'h0,        1'b0, 32'hFFFF8000);
    access(0, "sw_20",      1'b0, 1'b1, F3_SW,  32'h20, 32'h80015555, 1'b0, 32'h0);
    access(0, "sh_21_mis",  1'b0, 1'b1, F3_SH,  32'h21, 32'h00001234, 1'b1, 32'h0);
    access(0, "lw_20",      1'b1, 1'b0, F3_LW,  32'h20, 32'h0,        1'b0, 32'h80015555);
    access(0, "lh_22",      1'b1, 1'b0, F3_LH,  32'h22, 32'h0,        1'b0, 32'hFFFF8001);
    access(0, "lhu_22",     1'b1, 1'b0, F3_LHU, 32'h22, 32'h0,        1'b0, 32'h00008001);
    access(0, "lb_21",      1'b1, 1'b0, F3_LB,  32'h21, 32'h0,        1'b0, 32'h00000055);
    access(0, "lw_oor",     1'b1, 1'b0, F3_LW,  32'h400, 32'h0,       1'b1, 32'h0);
    access(0, "rd_wr_both", 1'b1, 1'b1, F3_SW,  32'h20, 32'h0,        1'b1, 32'h0);
    access(0, "lw_20_b",    1'b1, 1'b0, F3_LW,  32'h20, 32'h0,        1'b0, 32'h80015555);
    access(0, "ld_f3_011",  1'b1, 1'b0, 3'b011, 32'h20, 32'h0,        1'b1, 32'h0);
    access(0, "st_f3_100",  1'b0, 1'b1, 3'b100, 32'h20, 32'h0,        1'b1, 32'h0);
    access(0, "lw_22_mis",  1'b1, 1'b0, F3_LW,  32'h22, 32'h0,        1'b1, 32'h0);
    access(0, "lw_20_c",    1'b1, 1'b0, F3_LW,  32'h20, 32'h0,        1'b0, 32'h80015555);
    idle(1);

    // ---- WAIT_STATES = 0, back-to-back ----
    access(1, "b_sw_40",    1'b0, 1'b1, F3_SW,  32'h40, 32'hA5A5A5A5, 1'b0, 32'h0);
    access(1, "b_lw_40_0",  1'b1, 1'b0, F3_LW,  32'h40, 32'h0,        1'b0, 32'hA5A5A5A5);
    check("b2b:spacing0", 32'(spacing), 32'd2);
    access(1, "b_lw_40_1",  1'b1, 1'b0, F3_LW,  32'h40, 32'h0,        1'b0, 32'hA5A5A5A5);
    check("b2b:spacing1", 32'(spacing), 32'd2);
    access(1, "b_sw_44",    1'b0, 1'b1, F3_SW,  32'h44, 32'h01020304, 1'b0, 32'h0);
    access(1, "b_lb_45",    1'b1, 1'b0, F3_LB,  32'h45, 32'h0,        1'b0, 32'h00000003);
    access(1, "b_lh_46",    1'b1, 1'b0, F3_LH,  32'h46, 32'h0,        1'b0, 32'h00000102);
    idle(1);

    // ---- reset in the middle of a store ----
    access(0, "sw_30_init", 1'b0, 1'b1, F3_SW,  32'h30, 32'h11111111, 1'b0, 32'h0);
    access(0, "lw_30_init", 1'b1, 1'b0, F3_LW,  32'h30, 32'h0,        1'b0, 32'h11111111);
    drive(0, 1'b0, 1'b1, F3_SW, 32'h30, 32'hCAFEF00D);
    @(negedge clk);
    #1;
    check("rst_mid:stall_idle", {31'h0, get_stall(0)}, 32'h1);
    @(negedge clk);
    #1;
    check("rst_mid:stall_wait", {31'h0, get_stall(0)}, 32'h1);
    drive(0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    rst_n = 1'b0;
    #1;
    check("rst_mid:rdata",  get_rdata(0), 32'h0);
    check("rst_mid:rvalid", {31'h0, get_rvalid(0)}, 32'h0);
    check("rst_mid:fault",  {31'h0, get_fault(0)},  32'h0);
    check("rst_mid:stall",  {31'h0, get_stall(0)},  32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    hold_rd[0] = 32'h0;
    hold_rd[1] = 32'h0;
    idle(3);
    check("rst_mid:rvalid_after", {31'h0, get_rvalid(0)}, 32'h0);
    access(0, "lw_30_after", 1'b1, 1'b0, F3_LW, 32'h30, 32'h0,        1'b0, 32'h11111111);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
